alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 30 +++
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/rr_arbiter2.sv | 38 +++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared definitions for the two-requester ALU arbiter.
// Holds the FSM state encoding, the ALU control code constants and the
// supported-code check used to decide whether the ALU result is meaningful.
package alu_arbiter_pkg;

    // FSM state encoding
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;

    // ALU control codes
    localparam logic [3:0] AluAnd  = 4'd0;
    localparam logic [3:0] AluOr   = 4'd1;
    localparam logic [3:0] AluAdd  = 4'd2;
    localparam logic [3:0] AluBeq  = 4'd4;
    localparam logic [3:0] AluSub  = 4'd6;
    localparam logic [3:0] AluSlt  = 4'd7;
    localparam logic [3:0] AluAddi = 4'd8;

    // True when the shared ALU implements the given control code.
    function automatic logic is_supported(input logic [3:0] code);
        logic ok;
        case (code)
            AluAnd, AluOr, AluAdd, AluBeq, AluSub, AluSlt, AluAddi: ok = 1'b1;
            default:                                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-side signals of alu_arbiter.
//   req_*   : two requesters, packed per requester (control 4 bits each,
//             operands WIDTH bits each).
//   resp_*  : single response channel with valid/ready handshake.
//   alu_*   : drive to / result from the external combinational ALU.
// Modports: slave = the arbiter, master = the environment (requesters,
// response consumer and ALU).
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [7:0]         req_control;
    logic [2*WIDTH-1:0] req_op1;
    logic [2*WIDTH-1:0] req_op2;

    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [WIDTH-1:0]   resp_result;
    logic [7:0]         resp_status;
    logic               resp_err;

    logic [3:0]         alu_control;
    logic [WIDTH-1:0]   alu_operand_1;
    logic [WIDTH-1:0]   alu_operand_2;
    logic [WIDTH-1:0]   alu_result;
    logic [7:0]         alu_status;

    modport slave (
        input  req_valid, req_control, req_op1, req_op2, resp_ready, alu_result, alu_status,
        output req_ready, resp_valid, resp_id, resp_result, resp_status, resp_err,
        output alu_control, alu_operand_1, alu_operand_2
    );

    modport master (
        output req_valid, req_control, req_op1, req_op2, resp_ready, alu_result, alu_status,
        input  req_ready, resp_valid, resp_id, resp_result, resp_status, resp_err,
        input  alu_control, alu_operand_1, alu_operand_2
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant.
//   clk, rst_n : clock, asynchronous active-low reset.
//   en         : grants may be issued this cycle.
//   req        : request vector.
//   grant      : one-hot grant (combinational), zero when disabled or idle.
// The last-grant pointer resets to 1 so requester 0 wins the first tie, and
// moves only when a grant is actually issued.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|grant) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   clk   : clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : alu_arbiter_if slave port carrying the request, response and
//           ALU signals.
// One operation is in flight at a time: IDLE accepts, ISSUE drives the ALU
// from registered operands, RESP holds the captured result until taken.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       grant;
    logic             arb_en;
    logic             accept;
    logic             grant_id;

    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic             id_q;

    logic [WIDTH-1:0] result_q;
    logic [7:0]       status_q;
    logic             err_q;
    logic             supported;

    // Reset gates the arbiter so req_ready stays low while rst_n is low.
    assign arb_en   = (state_q == StIdle) && rst_n;
    assign accept   = |grant;
    assign grant_id = grant[1];

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (bus.req_valid),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  if (bus.resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture; the payload need not stay stable after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= 4'd0;
            op1_q  <= '0;
            op2_q  <= '0;
            id_q   <= 1'b0;
        end else if (accept) begin
            id_q <= grant_id;
            if (grant_id) begin
                ctrl_q <= bus.req_control[7:4];
                op1_q  <= bus.req_op1[2*WIDTH-1:WIDTH];
                op2_q  <= bus.req_op2[2*WIDTH-1:WIDTH];
            end else begin
                ctrl_q <= bus.req_control[3:0];
                op1_q  <= bus.req_op1[WIDTH-1:0];
                op2_q  <= bus.req_op2[WIDTH-1:0];
            end
        end
    end

    assign supported = is_supported(ctrl_q);

    // Result capture at the edge leaving ISSUE; unsupported codes report
    // an error with zeroed result and status instead of the ALU output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            status_q <= 8'd0;
            err_q    <= 1'b0;
        end else if (state_q == StIssue) begin
            result_q <= supported ? bus.alu_result : '0;
            status_q <= supported ? bus.alu_status : 8'd0;
            err_q    <= ~supported;
        end
    end

    assign bus.req_ready     = grant;
    assign bus.resp_valid    = (state_q == StResp);
    assign bus.resp_id       = id_q;
    assign bus.resp_result   = result_q;
    assign bus.resp_status   = status_q;
    assign bus.resp_err      = err_q;
    assign bus.alu_control   = ctrl_q;
    assign bus.alu_operand_1 = op1_q;
    assign bus.alu_operand_2 = op2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven vectors plus hand-written sequences for
// tie arbitration, backpressure and reset mid-operation. Expected responses
// are queued when a request is accepted and compared on retirement.
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [7:0]  st;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  valid;
        logic [3:0]  c0;
        logic [3:0]  c1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [1:0]  exp_grant;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[12];

    function automatic logic [7:0] stat_of(input logic [31:0] r, input logic err);
        if (err) return 8'h00;
        return {(r == 32'd0), 6'b0, r[31]};
    endfunction

    // Reference ALU: zero flag in bit 7, sign in bit 0; garbage for unknown codes.
    function automatic logic [39:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (c)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd4:    r = a - b;
            4'd6:    r = a - b;
            4'd7:    r = {31'b0, ($signed(a) < $signed(b))};
            4'd8:    r = a + b;
            default: return {8'hA5, 32'hDEADBEEF};
        endcase
        return {stat_of(r, 1'b0), r};
    endfunction

    always_comb begin
        {bus.alu_status, bus.alu_result} =
            alu_model(bus.alu_control, bus.alu_operand_1, bus.alu_operand_2);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
        bus.req_valid   = v;
        bus.req_control = {c1, c0};
        bus.req_op1     = {a1, a0};
        bus.req_op2     = {b1, b0};
    endtask

    // Waits (bounded) for an acceptance, checks the grant, queues the expectation.
    task automatic wait_accept(input logic [1:0] exp_grant, input logic [31:0] er,
                               input logic ee, output int waited);
        logic got;
        exp_t e;
        got    = 1'b0;
        waited = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            waited++;
            if ((bus.req_ready & bus.req_valid) != 2'b00) got = 1'b1;
        end
        check("accept_seen", {63'd0, got}, 64'd1);
        if (got) begin
            check("grant", {62'd0, bus.req_ready}, {62'd0, exp_grant});
            e.id  = exp_grant[1];
            e.res = ee ? 32'd0 : er;
            e.st  = stat_of(er, ee);
            e.err = ee;
            exp_q.push_back(e);
        end
    endtask

    // After an acceptance sampled at a negedge: drop the request, scramble
    // the payload and check the two-edge latency with resp_ready high.
    task automatic complete();
        @(posedge clk);
        #1;
        bus.req_valid   = 2'b00;
        bus.req_control = 8'($urandom);
        bus.req_op1     = {$urandom, $urandom};
        bus.req_op2     = {$urandom, $urandom};
        @(negedge clk);
        check("lat_issue", {63'd0, bus.resp_valid}, 64'd0);
        @(negedge clk);
        check("lat_resp", {63'd0, bus.resp_valid}, 64'd1);
        @(negedge clk);
        check("retired", {63'd0, bus.resp_valid}, 64'd0);
    endtask

    // Response monitor: scoreboard pop on handshake, stability while held.
    logic        hold_v = 1'b0;
    logic        hold_id;
    logic [31:0] hold_res;
    logic [7:0]  hold_st;
    logic        hold_err;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (bus.resp_valid) begin
                    check("no_ready_in_resp", {62'd0, bus.req_ready}, 64'd0);
                end
                if (hold_v && bus.resp_valid) begin
                    check("hold_id", {63'd0, bus.resp_id}, {63'd0, hold_id});
                    check("hold_result", {32'd0, bus.resp_result}, {32'd0, hold_res});
                    check("hold_status", {56'd0, bus.resp_status}, {56'd0, hold_st});
                    check("hold_err", {63'd0, bus.resp_err}, {63'd0, hold_err});
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    check("resp_expected", {63'd0, (exp_q.size() != 0)}, 64'd1);
                    if (exp_q.size() != 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("resp_id", {63'd0, bus.resp_id}, {63'd0, e.id});
                        check("resp_result", {32'd0, bus.resp_result}, {32'd0, e.res});
                        check("resp_status", {56'd0, bus.resp_status}, {56'd0, e.st});
                        check("resp_err", {63'd0, bus.resp_err}, {63'd0, e.err});
                    end
                    hold_v = 1'b0;
                end else if (bus.resp_valid) begin
                    hold_v   = 1'b1;
                    hold_id  = bus.resp_id;
                    hold_res = bus.resp_result;
                    hold_st  = bus.resp_status;
                    hold_err = bus.resp_err;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;

        // valid, c0, c1, a0, b0, a1, b1, grant, result, err
        vecs[0]  = '{2'b01, 4'd2, 4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 2'b01, 32'd12, 1'b0};
        vecs[1]  = '{2'b10, 4'd0, 4'd6, 32'd0, 32'd0, 32'd3, 32'd3, 2'b10, 32'd0, 1'b0};
        vecs[2]  = '{2'b01, 4'd3, 4'd0, 32'd9, 32'd9, 32'd0, 32'd0, 2'b01, 32'd0, 1'b1};
        vecs[3]  = '{2'b01, 4'd0, 4'd0, 32'hF0F0_FF00, 32'h0FF0_0FF0, 32'd0, 32'd0, 2'b01,
                     32'h00F0_0F00, 1'b0};
        vecs[4]  = '{2'b10, 4'd0, 4'd1, 32'd0, 32'd0, 32'h1200, 32'h0034, 2'b10,
                     32'h1234, 1'b0};
        vecs[5]  = '{2'b01, 4'd7, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 2'b01, 32'd1, 1'b0};
        vecs[6]  = '{2'b10, 4'd0, 4'd8, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 2'b10, 32'd0, 1'b0};
        vecs[7]  = '{2'b10, 4'd0, 4'd4, 32'd0, 32'd0, 32'd7, 32'd7, 2'b10, 32'd0, 1'b0};
        vecs[8]  = '{2'b11, 4'd2, 4'd2, 32'd1, 32'd1, 32'd50, 32'd50, 2'b01, 32'd2, 1'b0};
        vecs[9]  = '{2'b11, 4'd2, 4'd6, 32'd8, 32'd8, 32'd10, 32'd4, 2'b10, 32'd6, 1'b0};
        vecs[10] = '{2'b10, 4'd0, 4'd15, 32'd0, 32'd0, 32'd1, 32'd2, 2'b10, 32'd0, 1'b1};
        vecs[11] = '{2'b01, 4'd6, 4'd0, 32'd0, 32'd1, 32'd0, 32'd0, 2'b01, 32'hFFFF_FFFF, 1'b0};

        // Reset state, with both requesters tempting a grant.
        rst_n          = 1'b0;
        bus.resp_ready = 1'b1;
        drive(2'b11, 4'd2, 4'd2, 32'd1, 32'd2, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        check("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
        check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_resp_id", {63'd0, bus.resp_id}, 64'd0);
        check("rst_resp_result", {32'd0, bus.resp_result}, 64'd0);
        check("rst_resp_status", {56'd0, bus.resp_status}, 64'd0);
        check("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
        check("rst_alu_control", {60'd0, bus.alu_control}, 64'd0);
        check("rst_alu_op1", {32'd0, bus.alu_operand_1}, 64'd0);
        check("rst_alu_op2", {32'd0, bus.alu_operand_2}, 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst_n         = 1'b1;

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].valid, vecs[i].c0, vecs[i].c1, vecs[i].a0, vecs[i].b0,
                  vecs[i].a1, vecs[i].b1);
            wait_accept(vecs[i].exp_grant, vecs[i].exp_res, vecs[i].exp_err, w);
            complete();
        end

        // Backpressure: four RESP cycles with resp_ready low, requests pending.
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        drive(2'b01, 4'd2, 4'd0, 32'd100, 32'd23, 32'd0, 32'd0);
        wait_accept(2'b01, 32'd123, 1'b0, w);
        @(posedge clk);
        #1;
        drive(2'b11, 4'd2, 4'd2, 32'd100, 32'd23, 32'd1, 32'd2);
        @(negedge clk);
        check("bp_issue", {63'd0, bus.resp_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
            check("bp_req_ready", {62'd0, bus.req_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_retire_valid", {63'd0, bus.resp_valid}, 64'd1);
        check("no_accept_on_retire", {62'd0, bus.req_ready}, 64'd0);
        wait_accept(2'b10, 32'd3, 1'b0, w);
        check("bp_idle_next", w, 64'd1);
        complete();

        // Tie right after reset: grants 0,1,0,1 every 3 cycles.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(2'b11, 4'd2, 4'd2, 32'd1, 32'd2, 32'd10, 32'd20);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) wait_accept(2'b01, 32'd3, 1'b0, w);
            else            wait_accept(2'b10, 32'd30, 1'b0, w);
            if (k == 0) check("first_accept", w, 64'd1);
            else        check("issue_interval", w, 64'd3);
        end
        complete();

        // Reset in ISSUE abandons the operation and restores the pointer.
        @(posedge clk);
        #1;
        drive(2'b01, 4'd2, 4'd0, 32'd4, 32'd4, 32'd0, 32'd0);
        wait_accept(2'b01, 32'd8, 1'b0, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_issue_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_issue_req_ready", {62'd0, bus.req_ready}, 64'd0);
        check("rst_issue_alu_op1", {32'd0, bus.alu_operand_1}, 64'd0);
        check("rst_issue_alu_ctrl", {60'd0, bus.alu_control}, 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst_n         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", {63'd0, bus.resp_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        drive(2'b11, 4'd2, 4'd2, 32'd6, 32'd1, 32'd0, 32'd0);
        wait_accept(2'b01, 32'd7, 1'b0, w);
        complete();

        check("scoreboard_empty", exp_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
